// File: rtl/sdiv_seq_if.sv
// sdiv_seq_if -- operand/result handshake bundle for the sequential signed divider.
//
// Signals:
//   in_valid  : operand pair a/b is valid (master -> divider)
//   in_ready  : divider can accept an operand pair (divider -> master)
//   a, b      : signed dividend / divisor (master -> divider)
//   out_valid : q/r/dbz hold a valid result (divider -> master)
//   out_ready : consumer accepts the result (master -> divider)
//   q, r      : signed quotient / remainder (divider -> master)
//   dbz       : divide-by-zero flag for the current result (divider -> master)
//
// Modports: master = requester/consumer side, slave = the divider.
interface sdiv_seq_if #(
    parameter int DATAWIDTH = 64
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DATAWIDTH-1:0] a;
    logic signed [DATAWIDTH-1:0] b;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [DATAWIDTH-1:0] q;
    logic signed [DATAWIDTH-1:0] r;
    logic                        dbz;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, r, dbz
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, r, dbz
    );
endinterface

// File: rtl/sdiv_seq.sv
// sdiv_seq -- multi-cycle signed integer divider (restoring shift-subtract).
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-low reset
//   bus : sdiv_seq_if.slave -- in_valid/in_ready/a/b operand handshake,
//         out_valid/out_ready/q/r/dbz result handshake
//
// One operand pair is in flight at a time. An accepted pair is divided on
// magnitudes, one quotient bit per cycle for DATAWIDTH cycles, then the
// signs are applied: quotient truncates toward zero, remainder takes the
// dividend's sign. A zero divisor bypasses the iteration and returns
// q = -1, r = a, dbz = 1 one edge after accept.
module sdiv_seq #(
    parameter int DATAWIDTH = 64
) (
    input logic       clk,
    input logic       rst,
    sdiv_seq_if.slave bus
);

    localparam int CW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;

    // Unsigned magnitudes. The most-negative operand still fits, since its
    // magnitude 2^(W-1) is representable as a W-bit unsigned value.
    logic [DATAWIDTH-1:0]   quo;     // dividend bits shift out, quotient bits shift in
    logic [DATAWIDTH-1:0]   dvs;     // divisor magnitude
    logic [DATAWIDTH-1:0]   rem;     // partial remainder, always < dvs
    logic                   neg_q;
    logic                   neg_r;

    logic [DATAWIDTH:0]     rem_sh;
    logic [DATAWIDTH:0]     diff;
    logic [DATAWIDTH-1:0]   rem_nx;
    logic [DATAWIDTH-1:0]   quo_nx;

    function automatic logic [DATAWIDTH-1:0] mag(input logic signed [DATAWIDTH-1:0] x);
        logic [DATAWIDTH-1:0] ux;
        ux = $unsigned(x);
        return x[DATAWIDTH-1] ? (~ux + 1'b1) : ux;
    endfunction

    function automatic logic signed [DATAWIDTH-1:0] apply_sign(input logic [DATAWIDTH-1:0] m,
                                                               input logic neg);
        return neg ? $signed(~m + 1'b1) : $signed(m);
    endfunction

    // One restoring step. rem < dvs <= 2^(W-1), so rem_sh < 2^W and the top
    // bit of diff is a clean borrow flag.
    always_comb begin
        rem_sh = {rem, quo[DATAWIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        rem_nx = diff[DATAWIDTH] ? rem_sh[DATAWIDTH-1:0] : diff[DATAWIDTH-1:0];
        quo_nx = {quo[DATAWIDTH-2:0], ~diff[DATAWIDTH]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.q         <= '0;
            bus.r         <= '0;
            bus.dbz       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        if (bus.b == '0) begin
                            bus.q         <= '1;
                            bus.r         <= bus.a;
                            bus.dbz       <= 1'b1;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            quo   <= mag(bus.a);
                            dvs   <= mag(bus.b);
                            rem   <= '0;
                            neg_q <= bus.a[DATAWIDTH-1] ^ bus.b[DATAWIDTH-1];
                            neg_r <= bus.a[DATAWIDTH-1];
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATAWIDTH - 1)) begin
                        bus.q         <= apply_sign(quo_nx, neg_q);
                        bus.r         <= apply_sign(rem_nx, neg_r);
                        bus.dbz       <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/sdiv_seq.md
SDIV_SEQ -- requirements
Module: sdiv_seq

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 64, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 SHALL have port a, input signed, DATAWIDTH bits: dividend.
REQ-007 SHALL have port b, input signed, DATAWIDTH bits: divisor.
REQ-008 SHALL have port out_valid, output, 1 bit: result outputs are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port q, output signed, DATAWIDTH bits: quotient.
REQ-011 SHALL have port r, output signed, DATAWIDTH bits: remainder, with the same semantics as the combinational signed modulo component.
REQ-012 SHALL have port dbz, output, 1 bit: the divide-by-zero flag for the current result.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 SHALL hold in_ready = 1 only in IDLE.
REQ-015 SHALL hold out_valid = 1 only in DONE.
REQ-016 SHALL treat a rising edge with in_valid && in_ready as an accept: capture a and b, then enter CALC.
REQ-017 SHALL, in CALC, perform one restoring shift-subtract iteration per cycle on operand magnitudes, for exactly DATAWIDTH cycles, then enter DONE.
REQ-018 SHALL give a latency of DATAWIDTH+1 rising edges from accept edge to out_valid high; for DATAWIDTH=64 that is 65 edges.
REQ-019 SHALL truncate the quotient toward zero.
REQ-020 SHALL give the remainder the sign of the dividend, with |r| < |b|, so that a == q*b + r holds exactly.
REQ-021 SHALL set the quotient sign to sign(a) XOR sign(b) and apply it by two's-complement negation of the magnitude after the final iteration.
REQ-022 SHALL handle b == 0 as follows: skip CALC and go IDLE -> DONE in one edge, with q = all ones (-1), r = a and dbz = 1.
REQ-023 SHALL set dbz = 0 for every other operand pair.
REQ-024 SHALL handle a == most-negative and b == -1 as follows: q = most-negative (wrap), r = 0, dbz = 0, normal latency.
REQ-025 SHALL, in DONE, hold q, r, dbz and out_valid stable while out_ready = 0, for any number of cycles.
REQ-026 SHALL, in DONE with out_ready = 1, complete the transfer on that edge and return to IDLE, with in_ready = 1 on the next cycle.
REQ-027 SHALL allow no overlap: a new operand is never accepted in the same edge as result handoff, giving a minimum spacing of DATAWIDTH+2 edges between accepts.
REQ-028 SHALL ignore in_valid and operand changes outside IDLE; captured operands are unaffected.
REQ-029 SHALL drive q, r, dbz, out_valid and in_ready directly from registers.
REQ-030 SHALL update q, r and dbz only on entry to DONE.

Reset
REQ-031 SHALL, when rst = 0 at a rising edge, force the FSM to IDLE and clear q, r, dbz, out_valid and the internal iteration counter to 0.
REQ-032 SHALL drive in_ready = 1 after reset, from the first cycle following the reset edge.
REQ-033 SHALL, on reset during CALC or DONE, abort the operation with no out_valid pulse for it.
REQ-034 SHALL give reset priority over in_valid and out_ready on the same edge.

Verification
REQ-035 SHALL cover: a=7, b=2 -> after 65 edges out_valid=1, q=3, r=1, dbz=0.
REQ-036 SHALL cover sign cases, each in the form a, b -> q, r:
- a=-7, b=2 -> q=-3, r=-1
- a=7, b=-2 -> q=-3, r=1
- a=-7, b=-2 -> q=3, r=-1
REQ-037 SHALL cover: a=5, b=0 -> out_valid one edge after accept, q=-1, r=5, dbz=1.
REQ-038 SHALL cover: a=0x8000_0000_0000_0000, b=-1 -> q=0x8000_0000_0000_0000, r=0, dbz=0.
REQ-039 SHALL cover backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; raise out_ready -> IDLE next edge.
REQ-040 SHALL cover reset mid-operation: drive rst=0 at edge 30 of CALC -> next cycle in_ready=1, out_valid=0, q=r=0; a following accept of 9/4 -> q=2, r=1.
